// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Op codes, FSM states and the multicycle-op classifier.
package ex_muldiv_unit_pkg;

  localparam int MD_OPW = 3;

  typedef enum logic [MD_OPW-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

  function automatic logic is_md_op(logic [MD_OPW-1:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_div.sv
// Signed/unsigned 32-bit divider, combinational on latched operands.
// Quotient truncates toward zero; remainder takes the dividend sign.
module ex_muldiv_unit_div (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        dz
);

  logic        neg_a;
  logic        neg_b;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma    = neg_a ? -a : a;
    mb    = neg_b ? -b : b;
    dz    = (b == 32'd0);
    uq    = '0;
    ur    = '0;
    if (!dz) begin
      uq = ma / mb;
      ur = ma % mb;
    end
    // 0x80000000 / -1 wraps back to 0x80000000 through the negate
    quo = (neg_a ^ neg_b) ? -uq : uq;
    rem = neg_a ? -ur : ur;
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multicycle multiply/divide unit with architectural HI/LO.
// Fixed-latency FSM; result captured from combinational datapath at cnt==0.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  md_op_e      op_q;
  logic        ld;
  logic        sgn;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        dz;

  assign sgn = (op_q == MD_MULT) || (op_q == MD_DIV);

  // Low 64 bits of the extended product are correct for both signednesses
  assign prod = {{32{sgn & opa_q[31]}}, opa_q}
              * {{32{sgn & opb_q[31]}}, opb_q};

  ex_muldiv_unit_div u_div (
    .a   (opa_q),
    .b   (opb_q),
    .sgn (sgn),
    .quo (quo),
    .rem (rem),
    .dz  (dz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ld      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          unique case (1'b1)
            op == MD_MTHI: hi_d = a;
            op == MD_MTLO: lo_d = a;
            is_md_op(op): begin
              ld = 1'b1;
              if (op[1]) begin
                state_d = S_DIV;
                cnt_d   = CNT_W'(DIV_CYCLES - 1);
              end else begin
                state_d = S_MUL;
                cnt_d   = CNT_W'(MUL_CYCLES - 1);
              end
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == '0) begin
          if (!dz) begin
            hi_d = rem;
            lo_d = quo;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= MD_MULT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (ld) begin
        opa_q <= a;
        opb_q <= b;
        op_q  <= md_op_e'(op);
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed corner cases then random ops.
// Expected HI/LO come from a longint arithmetic model of the op semantics.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  ex_muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          keep;
    int          len;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  int nvec = 0;
  int ncmp = 0;
  int nerr = 0;
  bit bprev = 1'b0;
  int blen = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    exp_t e;
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint unsigned ux = 64'(x);
    longint unsigned uy = 64'(y);
    longint p;
    longint unsigned up;
    e.hi = '0;
    e.lo = '0;
    e.keep = 1'b0;
    e.len = 0;
    case (o)
      MD_MULT: begin
        p = sx * sy;
        {e.hi, e.lo} = p;
        e.len = 5;
      end
      MD_MULTU: begin
        up = ux * uy;
        {e.hi, e.lo} = up;
        e.len = 5;
      end
      MD_DIV: begin
        e.len = 10;
        if (y == 0) e.keep = 1'b1;
        else begin
          e.lo = 32'(sx / sy);
          e.hi = 32'(sx % sy);
        end
      end
      MD_DIVU: begin
        e.len = 10;
        if (y == 0) e.keep = 1'b1;
        else begin
          e.lo = 32'(ux / uy);
          e.hi = 32'(ux % uy);
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: checks each completed op and the idle architectural state
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      bprev = 1'b0;
      blen  = 0;
    end else begin
      if (start && busy)
        $display("note: start while busy at %0t (protocol violation)", $time);
      if (busy) begin
        blen++;
        if (!bprev && sb.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL unexpected_busy: got busy=1 expected 0 at %0t", $time);
        end
      end else if (bprev) begin
        if (sb.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL orphan_done: got completion expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          if (e.keep) begin
            e.hi = mhi;
            e.lo = mlo;
          end
          chk("busy_len", 32'(blen), 32'(e.len));
          chk("done_hi", hi, e.hi);
          chk("done_lo", lo, e.lo);
          mhi = e.hi;
          mlo = e.lo;
        end
        blen = 0;
      end else begin
        chk("idle_hi", hi, mhi);
        chk("idle_lo", lo, mlo);
      end
      bprev = busy;
    end
  end

  task automatic issue(logic [2:0] o, logic [31:0] x, logic [31:0] y, bit fl);
    int t = 0;
    while (busy && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (busy) begin
      ncmp++;
      nerr++;
      $display("FAIL idle_timeout: got busy=1 expected 0 at %0t", $time);
    end
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    flush = fl;
    if (!fl && is_md_op(o)) sb.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    if (!fl && o == MD_MTHI) mhi = x;
    if (!fl && o == MD_MTLO) mlo = x;
    nvec++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    issue(MD_MULT,  32'hFFFF_FFFD, 32'd5, 1'b0);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(MD_DIVU,  32'd7, 32'd2, 1'b0);
    issue(MD_MTHI,  32'h11, 32'd0, 1'b0);
    issue(MD_MTLO,  32'h22, 32'd0, 1'b0);
    issue(MD_DIV,   32'h1234, 32'd0, 1'b0);
    issue(MD_DIVU,  32'd5, 32'd0, 1'b0);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(MD_MTHI,  32'hABCD, 32'd0, 1'b1);
    chk("flushed_mthi_busy", 32'(busy), 32'd0);
    issue(MD_MTHI,  32'hABCD, 32'd0, 1'b0);
    issue(MD_MULT,  32'd3, 32'd4, 1'b1);

    // flush arriving while a mult is in flight must not disturb it
    issue(MD_MULT, 32'h0123_4567, 32'h89AB_CDEF, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;

    // second start while busy is ignored by the unit
    issue(MD_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    start = 1'b1;
    op    = MD_MTLO;
    a     = 32'hDEAD_BEEF;
    step();
    start = 1'b0;

    // reset mid-operation aborts and clears HI/LO
    issue(MD_MULT, 32'h5555_5555, 32'h3333_3333, 1'b0);
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    mhi = '0;
    mlo = '0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    repeat (300) begin
      ro = 3'($urandom_range(0, 5));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: ry = 32'($urandom_range(1, 16));
        2: ry = 32'hFFFF_FFFF;
        3: rx = 32'h8000_0000;
        default: ;
      endcase
      issue(ro, rx, ry, ($urandom_range(0, 9) == 0));
      if (busy && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
    end

    begin
      int t = 0;
      while (busy && t < 40) begin
        step();
        t++;
      end
    end
    repeat (3) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
